// File: rtl/gpu_write_scheduler.sv
// Write queue between the CPU bus synchroniser and the GPU memory write port.
// CPU writes are buffered and replayed during vblank or in idle render cycles.
module gpu_write_scheduler #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk_12_5875,
    input  logic                          rst_B,
    input  logic                          cpu_wr_valid,
    input  logic [15:0]                   cpu_wr_addr,
    input  logic [7:0]                    cpu_wr_data,
    input  logic                          vblank,
    input  logic                          render_req,
    input  logic                          ovf_clear,
    output logic                          mem_wen,
    output logic [15:0]                   mem_addr,
    output logic [7:0]                    mem_wdata,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [LW-1:0] FULL_LVL   = LW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    logic [15:0]   r_fifo_addr [FIFO_DEPTH];
    logic [7:0]    r_fifo_data [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [BW-1:0] r_burst;
    logic          r_yield;
    logic          r_wen;
    logic [15:0]   r_addr;
    logic [7:0]    r_wdata;
    logic          r_ovf;
    state_t        r_state;
    state_t        w_state_next;

    logic          w_grant;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    logic          w_drop;
    logic [LW-1:0] w_level_next;

    assign w_grant = vblank | (~render_req & ~r_yield);
    assign w_pop   = (r_level != '0) & w_grant;
    assign w_full  = (r_level == FULL_LVL);
    // A full queue still accepts when the head leaves in the same cycle.
    assign w_push  = cpu_wr_valid & (~w_full | w_pop);
    assign w_drop  = cpu_wr_valid & w_full & ~w_pop;

    always_comb begin
        w_level_next = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + 1'b1;
            2'b01:   w_level_next = r_level - 1'b1;
            default: w_level_next = r_level;
        endcase
    end

    always_ff @(posedge clk_12_5875) begin
        if (w_push) begin
            r_fifo_addr[r_wptr] <= cpu_wr_addr;
            r_fifo_data[r_wptr] <= cpu_wr_data;
        end
    end

    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_wen   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_level <= w_level_next;
            r_wen   <= w_pop;
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                r_addr  <= r_fifo_addr[r_rptr];
                r_wdata <= r_fifo_data[r_rptr];
            end
            if (w_drop)         r_ovf <= 1'b1;
            else if (ovf_clear) r_ovf <= 1'b0;
        end
    end

    // Outside vblank, every MAX_BURST back-to-back pops hand the port back for one cycle.
    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) begin
            r_burst <= '0;
            r_yield <= 1'b0;
        end else if (w_pop & ~vblank) begin
            if (r_burst == BURST_LAST) begin
                r_burst <= '0;
                r_yield <= 1'b1;
            end else begin
                r_burst <= r_burst + 1'b1;
                r_yield <= 1'b0;
            end
        end else begin
            r_burst <= '0;
            r_yield <= 1'b0;
        end
    end

    always_ff @(posedge clk_12_5875 or negedge rst_B) begin
        if (!rst_B) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_push) w_state_next = WAIT;
            WAIT:    if (w_grant) w_state_next = ISSUE;
            ISSUE: begin
                if (w_level_next == '0) w_state_next = IDLE;
                else if (!w_grant)      w_state_next = WAIT;
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign mem_wen    = r_wen;
    assign mem_addr   = r_addr;
    assign mem_wdata  = r_wdata;
    assign fifo_level = r_level;
    assign overflow   = r_ovf;

endmodule
